vf_pixel_server: RTL

- Responder (producer) side of the usb_camera_top video-frame fetch interface (vf_sof / vf_req / vf_byte).
- Buffers a push-style pixel byte stream from an upstream source (sensor capture, DMA, pattern logic) in a FIFO.
- Serves those bytes to the UVC core on demand, aligned to upstream frame boundaries.
- Sits between the capture path and usb_camera_top, in the clk (60 MHz) domain.

---
 rtl/vf_server_pkg.sv | 27 ++
 rtl/vf_sync_fifo.sv | 62 ++++++
 rtl/vf_pixel_server.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/vf_server_pkg.sv
// Shared types and helpers for the vf_pixel_server slice.
// Holds the FSM state type, the byte-counter width, the default fill byte
// and the elaboration-time frame-size helper.
package vf_server_pkg;

   localparam int         BYTE_CNT_W    = 29;
   localparam logic [7:0] FILL_BYTE_DEF = 8'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      STREAM = 2'd2
   } vf_state_e;

   // Bytes per frame. YUY2 packs two bytes per pixel; anything else is
   // treated as one byte per pixel.
   function automatic logic [BYTE_CNT_W-1:0] frame_bytes(
      input logic [31:0] ftype,
      input logic [13:0] w,
      input logic [13:0] h
   );
      logic [BYTE_CNT_W-1:0] px;
      px = BYTE_CNT_W'(w) * BYTE_CNT_W'(h);
      return (ftype == "YUY2") ? {px[BYTE_CNT_W-2:0], 1'b0} : px;
   endfunction

endpackage

// File: rtl/vf_sync_fifo.sv
// Synchronous FIFO with registered pop and no write-to-read bypass.
// The head entry is visible combinationally. A write into an empty FIFO
// becomes poppable on the following cycle. A full FIFO refuses writes even
// if a pop happens in the same cycle. flush empties it.
module vf_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_wr, do_rd;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level   = wr_ptr_q - rd_ptr_q;
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;

   // Pointer update; flush overrides any write or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_wr && !flush) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/vf_pixel_server.sv
// Frame-aligned byte server for the usb_camera_top vf_* fetch interface.
// Upstream pushes {px_sof, px_data} into a FIFO; the UVC core pulls bytes
// with vf_sof / vf_req. Build macro VF_PIXEL_SERVER_PATTERN_EN adds the
// pattern_en port and an incrementing test-pattern source.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no frame open; requests get FILL_BYTE, FIFO keeps filling
// SYNC   | frame opened; discarding untagged bytes until a px_sof byte
// STREAM | serving frame bytes; frame ends when byte_cnt hits FRAME_BYTES
module vf_pixel_server
   import vf_server_pkg::*;
#(
   parameter logic [31:0] FRAME_TYPE = "MONO",
   parameter logic [13:0] FRAME_W    = 14'd252,
   parameter logic [13:0] FRAME_H    = 14'd120,
   parameter int          FIFO_AW    = 10,
   parameter logic [7:0]  FILL_BYTE  = FILL_BYTE_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               px_valid,
   output logic               px_ready,
   input  logic [7:0]         px_data,
   input  logic               px_sof,
   input  logic               vf_sof,
   input  logic               vf_req,
   output logic [7:0]         vf_byte,
   output logic               frame_done,
   output logic [15:0]        underflow_cnt,
   output logic [FIFO_AW:0]   fifo_level
`ifdef VF_PIXEL_SERVER_PATTERN_EN
   ,
   input  logic               pattern_en
`endif
);

   localparam logic [BYTE_CNT_W-1:0] FRAME_BYTES = frame_bytes(FRAME_TYPE, FRAME_W, FRAME_H);
   localparam logic [BYTE_CNT_W-1:0] CNT_ONE     = BYTE_CNT_W'(1);

   vf_state_e             state_q, state_d;
   logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]            vf_byte_q, vf_byte_d;
   logic [15:0]           underflow_q, underflow_d;
   logic                  uf_inc;
   logic                  pop;
   logic                  pat_mode;

   logic [8:0]            fifo_rd_data;
   logic                  fifo_full, fifo_empty;
   logic                  head_sof;
   logic [7:0]            head_data;

`ifdef VF_PIXEL_SERVER_PATTERN_EN
   logic                  pat_q, pat_d;
   logic [7:0]            seed_q, seed_d;
   assign pat_mode = pat_q;
`else
   assign pat_mode = 1'b0;
`endif

   assign head_sof   = fifo_rd_data[8];
   assign head_data  = fifo_rd_data[7:0];
   assign px_ready   = pat_mode || !fifo_full;
   // Held high for the single cycle where the count sits at the frame size;
   // the FSM leaves STREAM/SYNC on that same cycle.
   assign frame_done = (state_q != IDLE) && (byte_cnt_q == FRAME_BYTES);

   assign vf_byte       = vf_byte_q;
   assign underflow_cnt = underflow_q;

   vf_sync_fifo #(
      .WIDTH (9),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (pat_mode),
      .wr_en   (px_valid && !pat_mode),
      .wr_data ({px_sof, px_data}),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Next-state, byte selection and counter updates.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      vf_byte_d  = vf_byte_q;
      uf_inc     = 1'b0;
      pop        = 1'b0;
`ifdef VF_PIXEL_SERVER_PATTERN_EN
      pat_d      = pat_q;
      seed_d     = seed_q;
`endif
      if (vf_sof) begin
         // A same-cycle vf_req is deliberately dropped here.
`ifdef VF_PIXEL_SERVER_PATTERN_EN
         pat_d = pattern_en;
         if (pattern_en) begin
            vf_byte_d  = seed_q;
            seed_d     = seed_q + 8'd1;
            byte_cnt_d = CNT_ONE;
            state_d    = STREAM;
         end else begin
            byte_cnt_d = '0;
            state_d    = SYNC;
         end
`else
         byte_cnt_d = '0;
         state_d    = SYNC;
`endif
      end else if (frame_done) begin
         state_d = IDLE;
         if (vf_req) begin
            vf_byte_d = FILL_BYTE;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (vf_req) begin
                  vf_byte_d = FILL_BYTE;
               end
            end
            SYNC: begin
               if (!fifo_empty && head_sof) begin
                  // Counting from the current value keeps any fill bytes
                  // served during SYNC inside the frame length.
                  pop        = 1'b1;
                  vf_byte_d  = head_data;
                  byte_cnt_d = byte_cnt_q + CNT_ONE;
                  state_d    = STREAM;
               end else begin
                  pop = !fifo_empty;
                  if (vf_req) begin
                     vf_byte_d  = FILL_BYTE;
                     uf_inc     = 1'b1;
                     byte_cnt_d = byte_cnt_q + CNT_ONE;
                  end
               end
            end
            STREAM: begin
               if (vf_req) begin
                  byte_cnt_d = byte_cnt_q + CNT_ONE;
                  if (pat_mode) begin
                     vf_byte_d = vf_byte_q + 8'd1;
                  end else if (!fifo_empty) begin
                     pop       = 1'b1;
                     vf_byte_d = head_data;
                  end else begin
                     vf_byte_d = FILL_BYTE;
                     uf_inc    = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      underflow_d = (uf_inc && (underflow_q != 16'hFFFF)) ? underflow_q + 16'd1 : underflow_q;
   end

   // Core state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         byte_cnt_q  <= '0;
         vf_byte_q   <= FILL_BYTE;
         underflow_q <= '0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         vf_byte_q   <= vf_byte_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef VF_PIXEL_SERVER_PATTERN_EN
   // Pattern-mode latch and per-frame seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q  <= 1'b0;
         seed_q <= 8'h00;
      end else begin
         pat_q  <= pat_d;
         seed_q <= seed_d;
      end
   end
`endif

endmodule
